sha256_msg_schedule: RTL and testbench
======================================

# sha256_msg_schedule

SHA-256 message scheduler: accepts one padded 512-bit message block and emits the 64 round words Wt, with the matching round constant Kt, one round per handshake. It sits directly upstream of the SHA-256 round/digest stage and drives that stage's Wt and Kt inputs. Its 16-word sliding window expands words 16..63 on the fly, so no 64-word storage is needed.

## Interface
Parameters: none. Word width is fixed at 32 and round count at 64; both are package constants.
- clk_i  in  1  single clock; all state on rising edge
- reset_i  in  1  asynchronous, active-high reset
- block_i  in  512  padded message block; word 0 = block_i[511:480], word 15 = block_i[31:0] (big-endian)
- v_i  in  1  block_i valid
- ready_o  out  1  block accepted on a cycle with v_i & ready_o
- v_o  out  1  Wt_o/Kt_o/round_o/last_o valid
- yumi_i  in  1  consumer takes current round; legal only when v_o=1
- Wt_o  out  32  message schedule word W[round_o]
- Kt_o  out  32  round constant K[round_o]
- round_o  out  6  current round index t, 0..63
- last_o  out  1  high when round_o==63 and v_o=1

## Operation
- States: IDLE, RUN. Reset puts the block in IDLE.
- IDLE: ready_o=1, v_o=0. On v_i=1, window[0..15] loads block words 0..15, round is cleared to 0, and the next state is RUN.
- RUN: ready_o=0, v_o=1, Wt_o=window[0], Kt_o=K[round].
- On yumi_i=1 in RUN:
  - window shifts down one entry.
  - window[15] ← σ1(window[14]) + window[9] + σ0(window[1]) + window[0], mod 2^32 (carries discarded).
  - round increments.
- σ0(x) = ROTR7(x) ^ ROTR18(x) ^ SHR3(x).
- σ1(x) = ROTR17(x) ^ ROTR19(x) ^ SHR10(x).
- These are true rotates, not shifts.
- Yumi at round 63 returns the block to IDLE. The final window shifts are don't-care.
- Boundary conditions:
  - v_i while in RUN is ignored and block_i is not sampled.
  - yumi_i with v_o=0 is ignored.
  - No yumi: all outputs hold stable indefinitely.
  - Round counter never wraps within a block; 63→IDLE is the only exit from RUN.
- Asynchronous reset mid-block aborts the block immediately; the partial block is discarded.

## Timing
- Reset values: ready_o=1, v_o=0, Wt_o=0, Kt_o=0, round_o=0, last_o=0. Internal window is cleared to 0.
- Block accepted at edge N → v_o=1 with W0/K0 in the cycle after N.
- Each yumi at edge M → next round is presented in the cycle after M. With continuous yumi, throughput is 1 round per cycle.
- Minimum block-to-block: 64 RUN cycles plus 1 IDLE cycle. Back-to-back acceptance on the last yumi is not supported.
- All outputs are registered or decoded from registers only; there is no combinational path from v_i or yumi_i to any output.

## Configuration
- SHA256_SCHED_KT_EN defined: Kt_o is driven from the internal 64-entry K constant ROM as above.
- SHA256_SCHED_KT_EN undefined: ROM is not compiled and Kt_o is tied to 32'h0. The downstream stage sources K itself.
- Handshake and Wt behaviour are identical in both builds.

## Structure
- Shared package sha256_pkg holds:
  - word typedef (logic [31:0])
  - round-index typedef (logic [5:0])
  - NUM_ROUNDS=64 and WINDOW_DEPTH=16
  - K constant array
  - σ0/σ1 functions, reused by future stages
- One sub-module, sha256_kt_rom: combinational round index → K lookup, instantiated only under SHA256_SCHED_KT_EN.

## Test plan
- Reset check: assert reset_i asynchronously mid-cycle → ready_o=1, v_o=0, round_o=0 immediately; no further outputs until a new block arrives.
- Vector "abc": block = 0x61626380, 13 zero words, then 0x00000000, 0x00000018, with continuous yumi. Required:
  - W0 = 0x61626380
  - W1..W14 = 0
  - W15 = 0x00000018
  - W16 = 0x61626380
  - W17 = 0x000F0000
  - K0 = 0x428a2f98
  - K63 = 0xc67178f2
  - last_o high only at round 63
- Stall: same block with random yumi gaps up to 5 cycles → identical Wt sequence; outputs stable during every stall cycle.
- Busy ignore: pulse v_i with a different block at round 10 → stream unchanged; the second block is accepted only after return to IDLE.
- Reset mid-block: reset at round 30, then send the "abc" block → stream restarts at W0 = 0x61626380 with round_o=0.
- Build without SHA256_SCHED_KT_EN: "abc" run → Kt_o = 0 every round; Wt sequence identical to the default build.

Source files
------------

// File: rtl/sha256_pkg.sv
// Shared SHA-256 types, sizes, round constants and the sigma0/sigma1 schedule
// functions used by the message scheduler and later round stages.
package sha256_pkg;

    localparam int WORD_W       = 32;
    localparam int BLOCK_W      = 512;
    localparam int NUM_ROUNDS   = 64;
    localparam int WINDOW_DEPTH = 16;

    typedef logic [WORD_W-1:0] word_t;
    typedef logic [5:0]        round_t;

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } sched_state_t;

    localparam word_t K [NUM_ROUNDS] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4c, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    // Rotates are written as concatenations so no bits are lost.
    function automatic word_t sigma0(input word_t x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
    endfunction

    function automatic word_t sigma1(input word_t x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'd0, x[31:10]};
    endfunction

endpackage

// File: rtl/sha256_kt_rom.sv
// Combinational lookup of the SHA-256 round constant K[t] for a round index.
module sha256_kt_rom
    import sha256_pkg::*;
(
    input  round_t round,
    output word_t  kt
);

    assign kt = K[round];

endmodule

// File: rtl/sha256_msg_schedule.sv
// SHA-256 message scheduler: expands one 512-bit block into W0..W63 with a
// 16-word sliding window. Kt_o comes from the K ROM only when SHA256_SCHED_KT_EN is defined.
module sha256_msg_schedule
    import sha256_pkg::*;
(
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic [BLOCK_W-1:0] block_i,
    input  logic               v_i,
    output logic               ready_o,
    output logic               v_o,
    input  logic               yumi_i,
    output logic [WORD_W-1:0]  Wt_o,
    output logic [WORD_W-1:0]  Kt_o,
    output logic [5:0]         round_o,
    output logic               last_o
);

    sched_state_t state_reg, state_next;
    word_t        window_reg [WINDOW_DEPTH];
    word_t        load_word  [WINDOW_DEPTH];
    word_t        shift_word [WINDOW_DEPTH];
    round_t       round_reg;
    logic         load_en;
    logic         shift_en;
    word_t        w_next;

    assign w_next = sigma1(window_reg[14]) + window_reg[9]
                  + sigma0(window_reg[1]) + window_reg[0];

    // Big-endian block unpack and the one-step-down shift source per entry.
    generate
        for (genvar gi = 0; gi < WINDOW_DEPTH; gi++) begin : g_window_src
            assign load_word[gi] = block_i[BLOCK_W-1-WORD_W*gi -: WORD_W];
            if (gi == WINDOW_DEPTH-1) begin : g_tail
                assign shift_word[gi] = w_next;
            end else begin : g_body
                assign shift_word[gi] = window_reg[gi+1];
            end
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        load_en    = 1'b0;
        shift_en   = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (v_i) begin
                    load_en    = 1'b1;
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (yumi_i) begin
                    shift_en = 1'b1;
                    if (round_reg == round_t'(NUM_ROUNDS-1)) begin
                        state_next = ST_IDLE;
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_reg <= ST_IDLE;
            round_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (load_en) begin
                round_reg <= '0;
            end else if (shift_en) begin
                round_reg <= round_reg + round_t'(1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < WINDOW_DEPTH; i++) begin
                window_reg[i] <= '0;
            end
        end else if (load_en) begin
            for (int i = 0; i < WINDOW_DEPTH; i++) begin
                window_reg[i] <= load_word[i];
            end
        end else if (shift_en) begin
            for (int i = 0; i < WINDOW_DEPTH; i++) begin
                window_reg[i] <= shift_word[i];
            end
        end
    end

    assign ready_o = (state_reg == ST_IDLE);
    assign v_o     = (state_reg == ST_RUN);
    assign Wt_o    = window_reg[0];
    assign round_o = round_reg;
    assign last_o  = v_o && (round_reg == round_t'(NUM_ROUNDS-1));

`ifdef SHA256_SCHED_KT_EN
    word_t kt_lookup;

    sha256_kt_rom u_kt_rom (
        .round (round_reg),
        .kt    (kt_lookup)
    );

    // Gated so Kt_o reads zero outside a block, matching its reset value.
    assign Kt_o = v_o ? kt_lookup : '0;
`else
    assign Kt_o = '0;
`endif

endmodule

// File: tb/tb_sha256_msg_schedule.sv
// Randomized self-checking bench for sha256_msg_schedule against a full
// 64-word schedule model computed directly from the SHA-256 recurrence.
module tb_sha256_msg_schedule;

    logic         clk;
    logic         reset_i;
    logic [511:0] block_i;
    logic         v_i;
    logic         ready_o;
    logic         v_o;
    logic         yumi_i;
    logic [31:0]  Wt_o;
    logic [31:0]  Kt_o;
    logic [5:0]   round_o;
    logic         last_o;

    int errors = 0;
    int checks = 0;

    logic [31:0]  exp_w [64];
    logic [511:0] abc_block;

    localparam logic [31:0] K_REF [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4c, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    sha256_msg_schedule dut (
        .clk_i   (clk),
        .reset_i (reset_i),
        .block_i (block_i),
        .v_i     (v_i),
        .ready_o (ready_o),
        .v_o     (v_o),
        .yumi_i  (yumi_i),
        .Wt_o    (Wt_o),
        .Kt_o    (Kt_o),
        .round_o (round_o),
        .last_o  (last_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] exp_kt(input int t);
`ifdef SHA256_SCHED_KT_EN
        return K_REF[t];
`else
        return (t < 0) ? 32'hffffffff : 32'h0;
`endif
    endfunction

    // Whole-schedule model: W[t] for t = 0..63 straight from the recurrence.
    task automatic build_ref(input logic [511:0] b);
        logic [31:0] s0, s1;
        for (int t = 0; t < 16; t++) exp_w[t] = b[511 - 32*t -: 32];
        for (int t = 16; t < 64; t++) begin
            s0 = rotr(exp_w[t-15], 7) ^ rotr(exp_w[t-15], 18) ^ (exp_w[t-15] >> 3);
            s1 = rotr(exp_w[t-2], 17) ^ rotr(exp_w[t-2], 19) ^ (exp_w[t-2] >> 10);
            exp_w[t] = s1 + exp_w[t-7] + s0 + exp_w[t-16];
        end
    endtask

    function automatic logic [511:0] rand_block();
        logic [511:0] b;
        for (int i = 0; i < 16; i++) b[32*i +: 32] = $urandom;
        return b;
    endfunction

    task automatic send_block(input logic [511:0] b);
        @(negedge clk);
        block_i = b;
        v_i     = 1'b1;
        @(negedge clk);
        v_i     = 1'b0;
        block_i = '0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset_i = 1'b0;
        checks++;
        if ({ready_o, v_o, Wt_o, Kt_o, round_o, last_o} !== {1'b1, 1'b0, 32'h0, 32'h0, 6'd0, 1'b0}) begin
            errors++;
            $display("FAIL reset_values got rdy=%0b v=%0b W=%h K=%h r=%0d last=%0b need 1 0 0 0 0 0",
                     ready_o, v_o, Wt_o, Kt_o, round_o, last_o);
        end
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (v_o !== 1'b0 || ready_o !== 1'b1) begin
                errors++;
                $display("FAIL reset_idle got v=%0b rdy=%0b need v=0 rdy=1", v_o, ready_o);
            end
        end
        $display("test_reset: done");
    endtask

    task automatic test_abc();
        build_ref(abc_block);
        send_block(abc_block);
        yumi_i = 1'b1;
        for (int t = 0; t < 64; t++) begin
            checks++;
            if (v_o !== 1'b1 || Wt_o !== exp_w[t] || Kt_o !== exp_kt(t) || round_o !== 6'(t) || last_o !== (t == 63)) begin
                errors++;
                $display("FAIL abc_round t=%0d got v=%0b W=%h K=%h r=%0d last=%0b need v=1 W=%h K=%h r=%0d last=%0b",
                         t, v_o, Wt_o, Kt_o, round_o, last_o, 1'b1, exp_w[t], exp_kt(t), t, (t == 63));
            end
            if (t == 0) begin
                checks++;
                if (Wt_o !== 32'h61626380) begin
                    errors++;
                    $display("FAIL abc_w0 got %h need 61626380", Wt_o);
                end
`ifdef SHA256_SCHED_KT_EN
                checks++;
                if (Kt_o !== 32'h428a2f98) begin
                    errors++;
                    $display("FAIL abc_k0 got %h need 428a2f98", Kt_o);
                end
`endif
            end
            if (t == 15) begin
                checks++;
                if (Wt_o !== 32'h00000018) begin
                    errors++;
                    $display("FAIL abc_w15 got %h need 00000018", Wt_o);
                end
            end
            if (t == 16) begin
                checks++;
                if (Wt_o !== 32'h61626380) begin
                    errors++;
                    $display("FAIL abc_w16 got %h need 61626380", Wt_o);
                end
            end
            if (t == 17) begin
                checks++;
                if (Wt_o !== 32'h000f0000) begin
                    errors++;
                    $display("FAIL abc_w17 got %h need 000f0000", Wt_o);
                end
            end
`ifdef SHA256_SCHED_KT_EN
            if (t == 63) begin
                checks++;
                if (Kt_o !== 32'hc67178f2) begin
                    errors++;
                    $display("FAIL abc_k63 got %h need c67178f2", Kt_o);
                end
            end
`endif
            @(negedge clk);
        end
        yumi_i = 1'b0;
        checks++;
        if (ready_o !== 1'b1 || v_o !== 1'b0 || last_o !== 1'b0 || Kt_o !== 32'h0) begin
            errors++;
            $display("FAIL abc_end got rdy=%0b v=%0b last=%0b K=%h need 1 0 0 0", ready_o, v_o, last_o, Kt_o);
        end
        $display("test_abc: done");
    endtask

    task automatic test_stall(input logic [511:0] b);
        int gap;
        build_ref(b);
        send_block(b);
        for (int t = 0; t < 64; t++) begin
            gap = $urandom_range(0, 5);
            for (int g = 0; g <= gap; g++) begin
                checks++;
                if (v_o !== 1'b1 || Wt_o !== exp_w[t] || Kt_o !== exp_kt(t) || round_o !== 6'(t) || last_o !== (t == 63)) begin
                    errors++;
                    $display("FAIL stall t=%0d g=%0d got v=%0b W=%h K=%h r=%0d need W=%h K=%h r=%0d",
                             t, g, v_o, Wt_o, Kt_o, round_o, exp_w[t], exp_kt(t), t);
                end
                yumi_i = (g == gap);
                @(negedge clk);
            end
            yumi_i = 1'b0;
        end
        checks++;
        if (ready_o !== 1'b1 || v_o !== 1'b0) begin
            errors++;
            $display("FAIL stall_end got rdy=%0b v=%0b need 1 0", ready_o, v_o);
        end
        $display("test_stall: done");
    endtask

    task automatic test_busy_ignore();
        logic [511:0] blk_a, blk_b;
        blk_a = rand_block();
        blk_b = rand_block();
        build_ref(blk_a);
        send_block(blk_a);
        yumi_i = 1'b1;
        for (int t = 0; t < 64; t++) begin
            checks++;
            if (Wt_o !== exp_w[t] || round_o !== 6'(t) || ready_o !== 1'b0) begin
                errors++;
                $display("FAIL busy_stream t=%0d got W=%h r=%0d rdy=%0b need W=%h r=%0d rdy=0",
                         t, Wt_o, round_o, ready_o, exp_w[t], t);
            end
            v_i     = (t == 10);
            block_i = (t == 10) ? blk_b : '0;
            @(negedge clk);
        end
        yumi_i = 1'b0;
        v_i    = 1'b0;
        checks++;
        if (ready_o !== 1'b1 || v_o !== 1'b0) begin
            errors++;
            $display("FAIL busy_idle got rdy=%0b v=%0b need 1 0", ready_o, v_o);
        end
        build_ref(blk_b);
        send_block(blk_b);
        yumi_i = 1'b1;
        for (int t = 0; t < 64; t++) begin
            checks++;
            if (v_o !== 1'b1 || Wt_o !== exp_w[t] || round_o !== 6'(t)) begin
                errors++;
                $display("FAIL busy_second t=%0d got v=%0b W=%h r=%0d need v=1 W=%h r=%0d",
                         t, v_o, Wt_o, round_o, exp_w[t], t);
            end
            @(negedge clk);
        end
        yumi_i = 1'b0;
        $display("test_busy_ignore: done");
    endtask

    task automatic test_reset_mid();
        logic [511:0] blk;
        blk = rand_block();
        build_ref(blk);
        send_block(blk);
        yumi_i = 1'b1;
        for (int t = 0; t < 30; t++) @(negedge clk);
        checks++;
        if (round_o !== 6'd30 || Wt_o !== exp_w[30]) begin
            errors++;
            $display("FAIL rst_mid_pre got r=%0d W=%h need r=30 W=%h", round_o, Wt_o, exp_w[30]);
        end
        #2 reset_i = 1'b1;
        #1;
        checks++;
        if (ready_o !== 1'b1 || v_o !== 1'b0 || round_o !== 6'd0 || Wt_o !== 32'h0 || last_o !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_async got rdy=%0b v=%0b r=%0d W=%h last=%0b need 1 0 0 0 0",
                     ready_o, v_o, round_o, Wt_o, last_o);
        end
        yumi_i = 1'b0;
        @(negedge clk);
        reset_i = 1'b0;
        repeat (2) begin
            @(negedge clk);
            checks++;
            if (v_o !== 1'b0) begin
                errors++;
                $display("FAIL rst_mid_idle got v=%0b need 0", v_o);
            end
        end
        build_ref(abc_block);
        send_block(abc_block);
        yumi_i = 1'b1;
        for (int t = 0; t < 64; t++) begin
            checks++;
            if (v_o !== 1'b1 || Wt_o !== exp_w[t] || round_o !== 6'(t) || Kt_o !== exp_kt(t)) begin
                errors++;
                $display("FAIL rst_mid_restart t=%0d got v=%0b W=%h r=%0d K=%h need v=1 W=%h r=%0d K=%h",
                         t, v_o, Wt_o, round_o, Kt_o, exp_w[t], t, exp_kt(t));
            end
            @(negedge clk);
        end
        yumi_i = 1'b0;
        $display("test_reset_mid: done");
    endtask

    initial begin
        reset_i   = 1'b1;
        v_i       = 1'b0;
        yumi_i    = 1'b0;
        block_i   = '0;
        abc_block = {32'h61626380, 416'd0, 32'h00000000, 32'h00000018};
        test_reset();
        test_abc();
        test_stall(abc_block);
        test_stall(rand_block());
        test_busy_ignore();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
